// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) serving the execute stage.
// Result is {remainder, quotient}; one quotient bit is resolved per clock.
module div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  cpu_clk_50M,
   input  logic                  cpu_rst_n,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     div_opdata1_i,
   input  logic [DATA_W-1:0]     div_opdata2_i,
   input  logic                  div_start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   div_result_o,
   output logic                  div_ready_o
);

   // state     | meaning
   // S_FREE    | idle, waiting for a start with operands
   // S_BYZERO  | divisor was zero, force zero result
   // S_ON      | iterating, one quotient bit per cycle
   // S_END     | result presented with ready until start drops
   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   dvd_q, dvd_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [DATA_W-1:0]   dsr_q, dsr_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0] result_d;
   logic                ready_d;

   logic [DATA_W:0]     rem_sh;
   logic                take;
   logic [DATA_W-1:0]   rem_it;
   logic [DATA_W-1:0]   quo_it;
   logic                last_it;
   logic                op1_neg;
   logic                op2_neg;

   // dvd_q starts as the dividend and fills with quotient bits from the bottom
   assign rem_sh  = {rem_q, dvd_q[DATA_W-1]};
   assign take    = (rem_sh >= {1'b0, dsr_q});
   assign rem_it  = take ? (rem_sh[DATA_W-1:0] - dsr_q) : rem_sh[DATA_W-1:0];
   assign quo_it  = {dvd_q[DATA_W-2:0], take};
   assign last_it = (cnt_q == CNT_W'(DATA_W-1));
   assign op1_neg = signed_div_i & div_opdata1_i[DATA_W-1];
   assign op2_neg = signed_div_i & div_opdata2_i[DATA_W-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      dsr_d     = dsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      ready_d   = 1'b0;
      result_d  = '0;
      case (state_q)
         S_FREE: begin
            if (div_start_i && !annul_i) begin
               if (div_opdata2_i == '0) begin
                  state_d = S_BYZERO;
               end else begin
                  dvd_d     = op1_neg ? -div_opdata1_i : div_opdata1_i;
                  dsr_d     = op2_neg ? -div_opdata2_i : div_opdata2_i;
                  neg_quo_d = op1_neg ^ op2_neg;
                  neg_rem_d = op1_neg;
                  rem_d     = '0;
                  cnt_d     = '0;
                  state_d   = S_ON;
               end
            end
         end
         S_BYZERO: begin
            dvd_d   = '0;
            rem_d   = '0;
            state_d = annul_i ? S_FREE : S_END;
         end
         S_ON: begin
            if (annul_i) begin
               state_d = S_FREE;
            end else begin
               dvd_d = quo_it;
               rem_d = rem_it;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_it) begin
                  // sign fix-up folds into the final iteration
                  if (neg_quo_q) dvd_d = -quo_it;
                  if (neg_rem_q) rem_d = -rem_it;
                  state_d = S_END;
               end
            end
         end
         S_END: begin
            if (annul_i || !div_start_i) begin
               state_d = S_FREE;
            end else begin
               ready_d  = 1'b1;
               result_d = {rem_q, dvd_q};
            end
         end
         default: state_d = S_FREE;
      endcase
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q      <= S_FREE;
         cnt_q        <= '0;
         dvd_q        <= '0;
         rem_q        <= '0;
         dsr_q        <= '0;
         neg_quo_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
         div_ready_o  <= 1'b0;
         div_result_o <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dvd_q        <= dvd_d;
         rem_q        <= rem_d;
         dsr_q        <= dsr_d;
         neg_quo_q    <= neg_quo_d;
         neg_rem_q    <= neg_rem_d;
         div_ready_o  <= ready_d;
         div_result_o <= result_d;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected {remainder, quotient},
// exact ready latency, annul, divide-by-zero and asynchronous reset behaviour.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        sgn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] res;
   logic        rdy;

   logic [63:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   div_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .cpu_clk_50M   (clk),
      .cpu_rst_n     (rst_n),
      .signed_div_i  (sgn),
      .div_opdata1_i (op1),
      .div_opdata2_i (op2),
      .div_start_i   (start),
      .annul_i       (annul),
      .div_result_o  (res),
      .div_ready_o   (rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, req);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with ready seen (or budget gone).
   // Operands are scrambled once the divide is accepted; they must be ignored.
   task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      lat   = -1;
      sgn   = s;
      op1   = a;
      op2   = b;
      start = 1'b1;
      sb.push_back(exp_res);
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (rdy) begin
            lat = k - 1;
            break;
         end
         op1 = $urandom;
         op2 = $urandom;
         sgn = 1'($urandom);
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_result"}, res, sb.pop_front());
   endtask

   task automatic drop_start(input string tag);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_ready_clr"}, 64'(rdy), 64'd0);
      chk({tag, "_result_clr"}, res, 64'd0);
   endtask

   initial begin
      int hold;
      int seen;
      rst_n = 1'b0;
      sgn   = 1'b0;
      op1   = '0;
      op2   = '0;
      start = 1'b0;
      annul = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 64'(rdy), 64'd0);
      chk("reset_result", res, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      drop_start("sdiv_m7_2");

      run_div("udiv_ffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'h7FFF_FFFF}, 33);
      drop_start("udiv_ffff_2");
      run_div("sdiv_ffff_2", 1'b1, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'h0000_0000}, 33);
      drop_start("sdiv_ffff_2");

      run_div("byzero", 1'b0, 32'd7, 32'd0, 64'd0, 2);
      hold = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rdy && res == 64'd0) hold++;
      end
      chk("byzero_hold", 64'(hold), 64'd5);
      drop_start("byzero");

      run_div("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
      drop_start("overflow");
      run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
      drop_start("udiv_100_7");

      // annul after ten iterations; annul held with start high must block any restart
      sgn   = 1'b0;
      op1   = 32'd1000;
      op2   = 32'd3;
      start = 1'b1;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      annul = 1'b1;
      @(posedge clk); #1;
      chk("annul_ready", 64'(rdy), 64'd0);
      chk("annul_result", res, 64'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (rdy) seen++;
      end
      chk("annul_no_ready", 64'(seen), 64'd0);
      annul = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      run_div("udiv_20_3", 1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);
      drop_start("udiv_20_3");

      // asynchronous reset while the result is presented
      run_div("udiv_1000_10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_end_ready", 64'(rdy), 64'd0);
      chk("rst_end_result", res, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_div("after_rst_end", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
      drop_start("after_rst_end");

      // asynchronous reset mid-iteration; start stays high so a fresh divide must take full latency
      sgn   = 1'b0;
      op1   = 32'd100;
      op2   = 32'd7;
      start = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_on_ready", 64'(rdy), 64'd0);
      chk("rst_on_result", res, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_div("after_rst_on", 1'b1, 32'd20, 32'hFFFF_FFFD, {32'd2, 32'hFFFF_FFFA}, 33);
      drop_start("after_rst_on");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU. Sits beside the execute stage and serves as its divide back-end.
- Execute drives operands, start and signedness, and stalls the pipeline until ready is returned.
- The result goes back to execute for the HI/LO write: remainder to HI, quotient to LO.
- One quotient bit is produced per clock.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- cpu_clk_50M  in  1  single clock; all state changes on the rising edge.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- div_opdata1_i  in  DATA_W  dividend.
- div_opdata2_i  in  DATA_W  divisor.
- div_start_i  in  1  1 = request or hold a divide; execute keeps it high until ready is seen.
- annul_i  in  1  1 = abandon the current divide (exception or flush).
- div_result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready = 1.
- div_ready_o  out  1  1 = result valid (DivResultReady).

Behaviour:
- Reset (asynchronous, cpu_rst_n = 0):
  - state = FREE, counter = 0, div_ready_o = 0, div_result_o = 0.
  - Applies immediately, including mid-divide.
- States are FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - If div_start_i = 1 and annul_i = 0 and divisor = 0 → BYZERO.
  - If div_start_i = 1 and annul_i = 0 and divisor ≠ 0:
    - latch operands; in signed mode latch the magnitudes (two's-complement negate if bit 31 = 1);
    - latch the sign flags; clear the partial remainder; counter = 0;
    - → ON.
  - Otherwise stay in FREE with ready = 0 and result = 0.
- BYZERO: quotient = 0, remainder = 0 → END next edge.
- ON, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtract the divisor from the upper DATA_W+1 bits.
  - If the difference is non-negative, keep it and set quotient bit = 1; else restore and set bit = 0.
  - counter increments each cycle.
  - After iteration DATA_W (counter reaches DATA_W) → END, with sign correction applied on that transition:
    - quotient negated iff signed mode and the operand signs differ;
    - remainder negated iff signed mode and the dividend is negative.
  - If annul_i = 1 in ON → FREE next edge; ready stays 0 and the result is cleared.
- END:
  - div_ready_o = 1 and div_result_o holds the final value.
  - Stay in END while div_start_i = 1.
  - If div_start_i = 0 → FREE next edge, clearing ready and result.
  - annul_i = 1 also forces → FREE.
- Latency:
  - Start sampled at edge N (non-zero divisor) → ready high after edge N+DATA_W+1 = N+33, held until start drops.
  - Divide by zero → ready after edge N+2.
- Operand handling: inputs are ignored outside FREE. Changes to operands or mode mid-divide have no effect.
- Arithmetic:
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0; modulo 2^32 wrap, no exception.
  - Unsigned mode never negates.
- Simultaneous events:
  - annul_i outranks div_start_i in every state.
  - A start held high on the edge after END→FREE begins a new divide; execute must drop start after seeing ready.

Test Plan:
- Signed: start, signed = 1, op1 = 0xFFFFFFF9 (−7), op2 = 2 → ready exactly 33 edges later; result = {0xFFFFFFFF, 0xFFFFFFFD}. Drop start → ready = 0 and result = 0 next edge.
- Unsigned: signed = 0, op1 = 0xFFFFFFFF, op2 = 2 → result {0x00000001, 0x7FFFFFFF}. Same operands with signed = 1 → {0xFFFFFFFF, 0x00000000}.
- Divide by zero: op1 = 7, op2 = 0 → ready after 2 edges, result 0. Hold start 5 cycles → ready stays high and the state stays END.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Then 100 / 7 unsigned → {0x00000002, 0x0000000E}.
- Annul and reset:
  - Pulse annul_i at iteration 10 → FREE next edge, no ready. A new start (20 / 3) completes with {2, 6}.
  - Assert cpu_rst_n = 0 mid-ON without a clock edge → outputs zero immediately.
